// File: rtl/aes_decrypt_seq_if.sv
// ---------------------------------------------------------------------------
// aes_decrypt_seq_if
//   Request/response bundle for the iterative AES-128 inverse cipher.
//
//   Handshake: `start` is a request that the block samples only while it is
//   idle. There is no separate ready: the block is ready exactly when `busy`
//   is low, and that includes the `done` cycle. A request seen while busy is
//   dropped, not queued. `key` and `ciphertext` are captured on the edge
//   that accepts `start`. Completion is a single-cycle `done` pulse, and
//   `plaintext` is valid in that cycle. `plaintext` then holds until the
//   next completion.
//
//   Signals
//     start      master -> slave   request, sampled in IDLE only
//     key        master -> slave   128-bit cipher key (round key 0)
//     ciphertext master -> slave   128-bit input block
//     plaintext  slave  -> master  128-bit registered result
//     busy       slave  -> master  block in flight
//     done       slave  -> master  one-cycle completion pulse
//     state_dbg  slave  -> master  current FSM state (0 IDLE, 1 KEXP, 2 ROUND)
// ---------------------------------------------------------------------------
interface aes_decrypt_seq_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    modport master (
        output start, key, ciphertext,
        input  plaintext, busy, done, state_dbg
    );

    modport slave (
        input  start, key, ciphertext,
        output plaintext, busy, done, state_dbg
    );
endinterface

// File: rtl/aes_decrypt_seq.sv
// ---------------------------------------------------------------------------
// aes_decrypt_seq
//   Iterative AES-128 inverse cipher with one round per clock. The round key
//   schedule is computed on the fly. The block first runs the forward key
//   expansion for ten cycles (KEXP) to reach K10. It then runs ten
//   inverse rounds (ROUND), unwinding the schedule back to K0 as it goes.
//   Byte n of any 128-bit bus sits at [8n+7:8n]. Column c is [32c+31:32c].
//
//   Ports
//     clk    sole clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    aes_decrypt_seq_if.slave (start/key/ciphertext in,
//            plaintext/busy/done/state_dbg out)
//
//   This file also holds the GF(2^8) helper package and the two S-box
//   leaf modules.
// ---------------------------------------------------------------------------

package aes_gf_pkg;
    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse computed as a^254. Left-to-right
    // square-and-multiply over the exponent bits 1111_1110. Zero maps to
    // zero, which is what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction
endpackage

// Forward S-box: inversion followed by the affine map.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    import aes_gf_pkg::*;

    logic [7:0] inv;

    assign inv      = gf_inv(in_byte);
    assign out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine map followed by inversion.
module aes_inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    import aes_gf_pkg::*;

    logic [7:0] pre;

    assign pre      = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]}
                    ^ {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
    assign out_byte = gf_inv(pre);
endmodule

module aes_decrypt_seq (
    input  logic              clk,
    input  logic              rst_n,
    aes_decrypt_seq_if.slave  bus
);
    import aes_gf_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEXP  = 2'd1,
        ROUND = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] plaintext_q, plaintext_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    // -----------------------------------------------------------------------
    // Key schedule
    // -----------------------------------------------------------------------
    // The four forward S-boxes are shared by both directions. Going forward
    // they see w3 of the current key. Going backward they need the
    // *recovered* w3, which is w3' ^ w2'. The mux picks the right word.
    logic [31:0]  ks_src;
    logic [31:0]  ks_rot;
    logic [31:0]  ks_sub;
    logic [31:0]  fw0, fw1, fw2, fw3;
    logic [31:0]  iw0, iw1, iw2, iw3;
    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;

    assign ks_src = (state_q == ROUND) ? (rk_q[127:96] ^ rk_q[95:64]) : rk_q[127:96];
    // RotWord(b0,b1,b2,b3) = (b1,b2,b3,b0); byte 0 is the low byte.
    assign ks_rot = {ks_src[7:0], ks_src[31:8]};

    for (genvar b = 0; b < 4; b++) begin : g_ksbox
        aes_sbox u_sbox (
            .in_byte  (ks_rot[8*b +: 8]),
            .out_byte (ks_sub[8*b +: 8])
        );
    end

    assign fw0    = rk_q[31:0] ^ ks_sub ^ {24'h0, rcon_q};
    assign fw1    = rk_q[63:32] ^ fw0;
    assign fw2    = rk_q[95:64] ^ fw1;
    assign fw3    = rk_q[127:96] ^ fw2;
    assign rk_fwd = {fw3, fw2, fw1, fw0};

    assign iw3    = rk_q[127:96] ^ rk_q[95:64];
    assign iw2    = rk_q[95:64] ^ rk_q[63:32];
    assign iw1    = rk_q[63:32] ^ rk_q[31:0];
    assign iw0    = rk_q[31:0] ^ ks_sub ^ {24'h0, rcon_q};
    assign rk_inv = {iw3, iw2, iw1, iw0};

    // -----------------------------------------------------------------------
    // State datapath: InvShiftRows folded into the S-box wiring
    // -----------------------------------------------------------------------
    // Output row r, column c takes its byte from input column (c - r) mod 4.
    // That rotates each row right by r.
    logic [127:0] isb;
    logic [127:0] t_round;
    logic [127:0] t_mix;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            aes_inv_sbox u_inv_sbox (
                .in_byte  (st_q[8*(4*((c - r + 4) % 4) + r) +: 8]),
                .out_byte (isb[8*(4*c + r) +: 8])
            );
        end
    end

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[8*i +: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                me[0] ^ mb[1] ^ md[2] ^ m9[3]};
    endfunction

    assign t_round = isb ^ rk_inv;
    assign t_mix   = {inv_mix_col(t_round[127:96]), inv_mix_col(t_round[95:64]),
                      inv_mix_col(t_round[63:32]),  inv_mix_col(t_round[31:0])};

    function automatic logic [7:0] xtime_inv(input logic [7:0] b);
        return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
    endfunction

    // -----------------------------------------------------------------------
    // FSM process 1: state and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            cnt_q       <= '0;
            rcon_q      <= '0;
            plaintext_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            cnt_q       <= cnt_d;
            rcon_q      <= rcon_d;
            plaintext_q <= plaintext_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)     state_d = KEXP;
            KEXP:    if (cnt_q == 4'd9) state_d = ROUND;
            ROUND:   if (cnt_q == 4'd0) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: datapath and registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        st_d        = st_q;
        rk_d        = rk_q;
        cnt_d       = cnt_q;
        rcon_d      = rcon_q;
        plaintext_d = plaintext_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    st_d   = bus.ciphertext;
                    rk_d   = bus.key;
                    cnt_d  = 4'd0;
                    rcon_d = 8'h01;
                    busy_d = 1'b1;
                end
            end
            KEXP: begin
                rk_d = rk_fwd;
                if (cnt_q == 4'd9) begin
                    // The last expansion step produces K10. Apply it right
                    // away as the initial AddRoundKey. rcon stays at 0x36
                    // because the inverse schedule starts from that value.
                    st_d  = st_q ^ rk_fwd;
                    cnt_d = 4'd9;
                end else begin
                    rcon_d = xtime(rcon_q);
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                rk_d   = rk_inv;
                rcon_d = xtime_inv(rcon_q);
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    // The final round has no InvMixColumns.
                    st_d        = t_round;
                    plaintext_d = t_round;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    st_d = t_mix;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.plaintext = plaintext_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_aes_decrypt_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_seq
//   Self-checking bench for aes_decrypt_seq. Reference blocks are produced
//   by a plain AES-128 forward cipher written over byte arrays. Its S-box
//   table is generated with the multiply-by-3 / divide-by-3 walk. Random
//   round trips take a random plaintext, encrypt it here, decrypt it in the
//   DUT and expect the original plaintext back. Known vectors use fixed
//   constants.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_decrypt_seq_if bus ();

    aes_decrypt_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] Z_CT   = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [127:0] exp_q[$];
    logic [127:0] last_pt;
    logic [7:0]   sbox_t [256];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] tb_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    task automatic gen_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   ks [176];
        logic [7:0]   s  [16];
        logic [7:0]   ns [16];
        logic [7:0]   tw [4];
        logic [7:0]   rc, t0, a0, a1, a2, a3;
        logic [127:0] res;
        for (int n = 0; n < 16; n++) ks[n] = key[8*n +: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tw[j] = ks[4*(i-1) + j];
            if (i % 4 == 0) begin
                t0    = tw[0];
                tw[0] = sbox_t[tw[1]] ^ rc;
                tw[1] = sbox_t[tw[2]];
                tw[2] = sbox_t[tw[3]];
                tw[3] = sbox_t[t0];
                rc    = tb_xt(rc);
            end
            for (int j = 0; j < 4; j++) ks[4*i + j] = ks[4*(i-4) + j] ^ tw[j];
        end
        for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ ks[n];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int n = 0; n < 16; n++) s[n] = sbox_t[s[n]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    ns[4*c + r] = s[4*((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = ns[4*c]; a1 = ns[4*c+1]; a2 = ns[4*c+2]; a3 = ns[4*c+3];
                    ns[4*c]   = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
                    ns[4*c+1] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
                    ns[4*c+2] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
                    ns[4*c+3] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = ns[n] ^ ks[16*rnd + n];
        end
        for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    // All driving and sampling happens 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle. On return the accept edge has passed.
    task automatic issue(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] exp_pt);
        bus.start      = 1'b1;
        bus.key        = k;
        bus.ciphertext = ct;
        exp_q.push_back(exp_pt);
        tick();
        bus.start = 1'b0;
    endtask

    // Called right after the accept edge. Returns in the done cycle.
    task automatic wait_done(input bit rand_in);
        int           lat;
        int           busy_cycles;
        int           hold_bad;
        bit           seen;
        logic [127:0] exp_pt;
        lat         = 0;
        seen        = 1'b0;
        busy_cycles = bus.busy ? 1 : 0;
        hold_bad    = (bus.plaintext !== last_pt) ? 1 : 0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cycles++;
                if (bus.plaintext !== last_pt) hold_bad++;
                if (rand_in) begin
                    bus.start      = 1'($urandom_range(0, 1));
                    bus.key        = rand128();
                    bus.ciphertext = rand128();
                end
            end
        end
        if (rand_in) bus.start = 1'b0;
        exp_pt = exp_q.pop_front();
        check("done_seen",    128'(seen), 128'(1));
        check("latency",      128'(lat), 128'(20));
        check("busy_cycles",  128'(busy_cycles), 128'(20));
        check("busy_at_done", 128'(bus.busy), 128'(0));
        check("pt_hold",      128'(hold_bad), 128'(0));
        check("plaintext",    bus.plaintext, exp_pt);
        last_pt = exp_pt;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] k, pt;
        int           dones;

        bus.start      = 1'b0;
        bus.key        = '0;
        bus.ciphertext = '0;
        last_pt        = '0;
        gen_sbox();

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        check("rst_plaintext", bus.plaintext, 128'(0));
        check("rst_busy",      128'(bus.busy), 128'(0));
        check("rst_done",      128'(bus.done), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // FIPS-197 C.1
        issue(C1_KEY, C1_CT, C1_PT);
        wait_done(1'b0);
        tick();
        check("done_one_cycle", 128'(bus.done), 128'(0));
        check("c1_hold",        bus.plaintext, C1_PT);

        // Zero key
        issue(128'(0), Z_CT, 128'(0));
        wait_done(1'b0);

        // Input isolation: start and data churn while busy
        tick();
        issue(C1_KEY, C1_CT, C1_PT);
        wait_done(1'b1);
        tick();
        check("iso_no_queue_done", 128'(bus.done), 128'(0));
        check("iso_no_queue_busy", 128'(bus.busy), 128'(0));
        check("iso_pt",            bus.plaintext, C1_PT);

        // Reset 12 cycles into a block
        issue(C1_KEY, C1_CT, C1_PT);
        repeat (11) tick();
        rst_n = 1'b0;
        #1;
        check("arst_plaintext", bus.plaintext, 128'(0));
        check("arst_busy",      128'(bus.busy), 128'(0));
        check("arst_done",      128'(bus.done), 128'(0));
        exp_q.delete();
        last_pt = '0;
        tick();
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("arst_no_done", 128'(dones), 128'(0));
        issue(128'(0), Z_CT, 128'(0));
        wait_done(1'b0);

        // Back-to-back: second request in the done cycle
        k  = rand128();
        pt = rand128();
        tick();
        issue(k, model_encrypt(k, pt), pt);
        wait_done(1'b0);
        k  = rand128();
        pt = rand128();
        issue(k, model_encrypt(k, pt), pt);
        wait_done(1'b0);

        // Random round trips with 0..2 idle cycles between blocks
        for (int n = 0; n < 1000; n++) begin
            k  = rand128();
            pt = rand128();
            repeat ($urandom_range(0, 2)) tick();
            issue(k, model_encrypt(k, pt), pt);
            wait_done(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_seq.md
# aes_decrypt_seq

Iterative AES-128 inverse cipher (FIPS-197 §5.3), one round per clock, with on-the-fly key schedule. It is the decrypt-side counterpart to the combinational `aes_encrypt` datapath and feeds the `mode = 0` plaintext path of the top level. It uses the same column-major byte order: byte *n* occupies bits `[8n+7:8n]`, and column *c* is word `[32c+31:32c]`.

## Interface
- No parameters. Key size is fixed at 128 bits; Nr = 10.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `key`  in  128  cipher key (round key 0); latched when start is accepted.
- `ciphertext`  in  128  input block; latched when start is accepted.
- `plaintext`  out  128  registered result; holds until the next accepted start.
- `busy`  out  1  high from the cycle after acceptance until done.
- `done`  out  1  one-cycle pulse; plaintext is valid in that cycle.

## Operation
- The FSM has three states: IDLE, KEXP, ROUND. Registers are `st` (128), `rk` (128), a 4-bit `cnt`, and an 8-bit `rcon`.
- **IDLE, start = 1 (edge E0):**
  - `st` <= ciphertext, `rk` <= key, `cnt` <= 0, `rcon` <= 0x01.
  - Go to KEXP. busy <= 1.
- **KEXP (edges E1..E10):** forward key expansion.
  - rk <= expand(rk, rcon). rcon <= xtime(rcon), giving 01,02,…,80,1b,36. cnt++.
  - On E10 (cnt = 9), also: st <= st ^ expand(rk, rcon), which is the initial AddRoundKey with K10. rk <= K10. rcon stays 0x36 (no xtime on this edge). cnt <= 9.
  - Go to ROUND.
- **Forward expand:**
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {24'h0, rcon}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - Here RotWord(b0,b1,b2,b3) = (b1,b2,b3,b0), and rcon occupies the byte-0 position (bits `[7:0]`).
- **ROUND (edges E11..E20), with r = cnt going 9 down to 0:**
  - k = invexpand(rk, rcon), i.e. K_r.
  - t = InvSubBytes(InvShiftRows(st)) ^ k.
  - st <= (r ≠ 0) ? InvMixColumns(t) : t.
  - rk <= k. rcon <= xtime⁻¹(rcon): 36→1b→80→…→01, where for odd rcon xtime⁻¹ = (rcon ^ 0x1b) >> 1 | 0x80, else rcon >> 1. cnt--.
- **Inverse expand:**
  - w3 = w3' ^ w2'
  - w2 = w2' ^ w1'
  - w1 = w1' ^ w0'
  - w0 = w0' ^ SubWord(RotWord(w3)) ^ rcon, using the newly derived w3.
- **At r = 0 (edge E20):**
  - plaintext <= t, done <= 1, busy <= 0. Go to IDLE.
- **Inputs after acceptance:** `start` while busy is ignored and not queued. Changes on `key` or `ciphertext` after E0 have no effect.
- **Arithmetic:**
  - InvShiftRows rotates row *r* right by *r* columns.
  - InvMixColumns multiplies each column by {0e,0b,0d,09} over GF(2⁸) with polynomial 0x11b. All operations are pure XOR/byte logic.
- **S-boxes:** 4 forward S-boxes serve the key schedule (shared between KEXP and ROUND via the rk word mux). There are 16 inverse S-boxes on the state. Both are leaf modules (`aes_sbox`, `aes_inv_sbox`) implemented alongside this block.

## Timing
- **Reset (rst_n = 0, any time):**
  - plaintext = 0, busy = 0, done = 0. FSM to IDLE; st/rk/cnt/rcon = 0.
  - An in-flight block is aborted, with no done pulse.
  - The first accept is possible on the first edge after rst_n rises.
- **Latency:**
  - start sampled at E0 → done high in the cycle after E20 (20 cycles after the accept edge).
  - busy is high after E0 through E19, and low in the done cycle.
- **done:** exactly one cycle. It is deasserted on the next edge regardless of start.
- **Back-to-back:** start high during the done cycle is accepted (FSM is in IDLE). Maximum throughput is one block per 21 cycles.
- **Outputs:** all are registered. plaintext is unchanged from the done cycle until E0 of the next accepted start, then holds its old value until the next done.

## Test plan
- **FIPS-197 C.1:**
  - key bus `0f0e0d0c0b0a09080706050403020100`, ciphertext bus `5ac5b47080b7cdd830047b6ad8e0c469`.
  - Required: plaintext bus `ffeeddccbbaa99887766554433221100`, done exactly 20 cycles after the accept edge, busy high for 20 cycles.
- **Zero key (matches the top-level tied key):**
  - ciphertext bus `2e2b34ca59fa4c883b2c8aefd44be966`.
  - Required: plaintext = 0.
- **Input isolation:** start the C.1 vector, then toggle start and randomize key/ciphertext every cycle while busy → single done, C.1 plaintext unchanged.
- **Reset mid-operation:**
  - Drop rst_n at cycle 12 after accept: outputs must go to 0 immediately (asynchronously), and no done may follow.
  - Then re-issue the zero-key vector → correct result 20 cycles later.
- **Back-to-back:** assert start in the done cycle with a new vector → second done exactly 21 cycles after the first; first plaintext is held until then.
- **Round-trip:** 1000 random key/plaintext pairs through `aes_encrypt` → this block → recovered plaintext matches bit-exact.
